// File: rtl/tcm_axis_capture.sv
// AXI-Stream single-packet capture into an inferred TCM buffer, with synchronous random-access readback.
// Optional macro TCM_AXIS_CAPTURE_RD_PIPE_EN adds an output register on the readback path (latency 2).
//
// state      | meaning
// -----------+----------------------------------------------------------
// ST_IDLE    | not armed, TREADY low, status from last capture retained
// ST_CAPTURE | armed, TREADY high, every beat written to mem[wr_ptr]
// ST_DONE    | packet ended (TLAST or full without wrap), status held
module tcm_axis_capture #(
    parameter int C_S_AXIS_TDATA_WIDTH = 32,
    parameter int C_DEPTH              = 32,
    parameter int C_WRAP_MODE          = 0,
    localparam int ADDR_W              = $clog2(C_DEPTH)
) (
    input  logic                            S_AXIS_ACLK,
    input  logic                            S_AXIS_ARESETN,
    input  logic                            S_AXIS_TVALID,
    output logic                            S_AXIS_TREADY,
    input  logic [C_S_AXIS_TDATA_WIDTH-1:0] S_AXIS_TDATA,
    input  logic                            S_AXIS_TLAST,
    input  logic                            ctrl_arm,
    input  logic                            ctrl_abort,
    input  logic [ADDR_W-1:0]               rd_addr,
    output logic [C_S_AXIS_TDATA_WIDTH-1:0] rd_data,
    output logic                            stat_busy,
    output logic                            stat_done,
    output logic [ADDR_W:0]                 stat_len,
    output logic                            stat_overflow
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_DONE    = 2'd2
    } state_t;

    localparam logic [ADDR_W:0]   LEN_FULL  = (ADDR_W+1)'(C_DEPTH);
    localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(C_DEPTH - 1);

    state_t                          state, state_nxt;
    logic [ADDR_W-1:0]               wr_ptr, wr_ptr_nxt;
    logic [ADDR_W:0]                 len, len_nxt;
    logic                            ovf, ovf_nxt;
    logic                            beat;
    logic [C_S_AXIS_TDATA_WIDTH-1:0] mem [C_DEPTH];
    logic [C_S_AXIS_TDATA_WIDTH-1:0] rd_q;

    // TREADY is a decode of the state flop, so it drops with reset without a clock edge.
    assign S_AXIS_TREADY = (state == ST_CAPTURE);
    assign beat          = S_AXIS_TVALID & S_AXIS_TREADY;
    assign stat_busy     = (state == ST_CAPTURE);
    assign stat_done     = (state == ST_DONE);
    assign stat_len      = len;
    assign stat_overflow = ovf;

    always_ff @(posedge S_AXIS_ACLK or negedge S_AXIS_ARESETN) begin
        if (!S_AXIS_ARESETN) begin
            state  <= ST_IDLE;
            wr_ptr <= '0;
            len    <= '0;
            ovf    <= 1'b0;
        end else begin
            state  <= state_nxt;
            wr_ptr <= wr_ptr_nxt;
            len    <= len_nxt;
            ovf    <= ovf_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        wr_ptr_nxt = wr_ptr;
        len_nxt    = len;
        ovf_nxt    = ovf;
        case (state)
            ST_IDLE, ST_DONE: begin
                if (ctrl_arm && !ctrl_abort) begin
                    state_nxt  = ST_CAPTURE;
                    wr_ptr_nxt = '0;
                    len_nxt    = '0;
                    ovf_nxt    = 1'b0;
                end
            end
            ST_CAPTURE: begin
                if (beat) begin
                    // Power-of-two depth: the increment wraps to 0 on its own.
                    wr_ptr_nxt = wr_ptr + 1'b1;
                    if (len != LEN_FULL) begin
                        len_nxt = len + 1'b1;
                    end
                    if (S_AXIS_TLAST) begin
                        state_nxt = ST_DONE;
                    end else if (wr_ptr == ADDR_LAST) begin
                        ovf_nxt = 1'b1;
                        if (C_WRAP_MODE == 0) begin
                            state_nxt = ST_DONE;
                        end
                    end
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
        // Abort overrides any transition, but the beat on this edge is still counted above.
        if (ctrl_abort) begin
            state_nxt = ST_IDLE;
        end
    end

    always_ff @(posedge S_AXIS_ACLK) begin
        if (beat) begin
            mem[wr_ptr] <= S_AXIS_TDATA;
        end
    end

    // Read-first: a same-edge write lands after the old word has been sampled.
    always_ff @(posedge S_AXIS_ACLK or negedge S_AXIS_ARESETN) begin
        if (!S_AXIS_ARESETN) begin
            rd_q <= '0;
        end else begin
            rd_q <= mem[rd_addr];
        end
    end

`ifdef TCM_AXIS_CAPTURE_RD_PIPE_EN
    logic [C_S_AXIS_TDATA_WIDTH-1:0] rd_pipe;

    always_ff @(posedge S_AXIS_ACLK or negedge S_AXIS_ARESETN) begin
        if (!S_AXIS_ARESETN) begin
            rd_pipe <= '0;
        end else begin
            rd_pipe <= rd_q;
        end
    end

    assign rd_data = rd_pipe;
`else
    assign rd_data = rd_q;
`endif

endmodule
